tx_top: RTL and testbench
=========================

TX_TOP -- requirements
Module: tx_top

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, meaning the system clock frequency in Hz.
REQ-002 SHALL have parameter DEPTH, default 8, meaning the TX FIFO depth in entries.
REQ-003 SHALL have parameter DBITS, default 8, meaning the maximum data width.
REQ-004 SHALL have parameter SBITS, default 2, meaning the maximum number of stop bits.
REQ-005 SHALL have port i_clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-006 SHALL have port i_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port i_wr, input, 1 bit: write strobe, one byte per cycle high.
REQ-008 SHALL have port i_wr_data, input, DBITS bits: byte to enqueue.
REQ-009 SHALL have port i_d_num, input, 1 bit: 0 = 7 data bits, 1 = 8 data bits.
REQ-010 SHALL have port i_s_num, input, 1 bit: 0 = 1 stop bit, 1 = 2 stop bits.
REQ-011 SHALL have port i_par, input, 2 bits: 00 = none, 01 = even, 10 = odd, 11 = none.
REQ-012 SHALL have port i_bd_rate, input, 2 bits: 00 = 1200, 01 = 2400, 10 = 4800, 11 = 9600 baud.
REQ-013 SHALL have port o_tx, output, 1 bit: serial line, idle high.
REQ-014 SHALL have port o_full, output, 1 bit: FIFO full.
REQ-015 SHALL have port o_busy, output, 1 bit: frame in progress.

Function
REQ-016 SHALL generate a 16x oversampling tick every MAX_TICKS = ceil(CLK_FREQ/(baud*16)) clocks, with 1200 baud giving 2605 and 9600 giving 326.
REQ-017 SHALL make every bit exactly 16 ticks, i.e. 16*MAX_TICKS clocks, and SHALL restart the divider and tick counter at frame start.
REQ-018 SHALL implement an FSM with states IDLE, START, DATA, PARITY and STOP.
REQ-019 SHALL, in IDLE with the FIFO non-empty, pop one entry, latch i_d_num/i_s_num/i_par/i_bd_rate, and enter START.
REQ-020 SHALL, with i_wr sampled at edge k into an empty idle block, drive o_tx low and o_busy high from edge k+1.
REQ-021 SHALL transmit the start bit low, then 7 or 8 data bits LSB first, with bit 7 not sent in 7-bit mode.
REQ-022 SHALL insert PARITY only when i_par is 01 or 10, with even = XOR of the transmitted data bits and odd = its inverse.
REQ-023 SHALL hold STOP high for 1 or 2 bit times.
REQ-024 SHALL, at the end of STOP with the FIFO non-empty, start the next START on the following edge with no idle gap; otherwise it SHALL return to IDLE with o_busy low.
REQ-025 SHALL ignore configuration changes during a frame until the next frame start.
REQ-026 SHALL drive o_tx from a register, glitch-free.
REQ-027 SHALL implement the FIFO as circular DEPTH-entry storage with wrap-around pointers and an occupancy count.
REQ-028 SHALL assert o_full when the count equals DEPTH.
REQ-029 SHALL drop a write while o_full is high, even if a pop occurs in the same cycle, leaving contents and pointers unchanged.
REQ-030 SHALL, on a simultaneous write and pop when not full, store the new entry, pop the oldest, and leave the count unchanged.

Reset
REQ-031 SHALL, while i_rst_n is low, asynchronously force o_tx = 1, o_busy = 0, o_full = 0, the FSM to IDLE, and all FIFO pointers and count, the divider and the tick/bit counters to 0.
REQ-032 SHALL, on reset mid-frame, abort the frame immediately, discard queued data, and not resume after deassertion.

Verification
REQ-033 SHALL verify 8N1 at 1200 baud by writing 0xA5 -> o_tx low for 41680 clocks, then 1,0,1,0,0,1,0,1 each 41680 clocks, stop high, and o_busy high for 416800 clocks total.
REQ-034 SHALL verify 7N2 by writing 0xB5 -> 7 data bits 1,0,1,0,1,1,0 then two stop bits, 10 bit times total, with bit 7 never driven.
REQ-035 SHALL verify parity by writing 0x03 with 8E1 -> parity bit 0, and 0x03 with 8O1 -> parity bit 1, each in an 11-bit frame.
REQ-036 SHALL verify 9600-baud 8E1 by writing 0x81 -> every bit exactly 5216 clocks and parity 0.
REQ-037 SHALL verify overflow with DEPTH=8 by writing 10 distinct bytes on consecutive cycles while idle -> o_full high after the 9th write, the 10th byte dropped, the first 9 bytes sent back-to-back in order, and o_busy continuous.
REQ-038 SHALL verify reset mid-frame by asserting i_rst_n low during DATA with 3 bytes queued -> o_tx = 1, o_busy = 0, o_full = 0 immediately, and no further frames after release.

Source files
------------

// File: rtl/tx_top.sv
// UART transmitter with a circular TX FIFO, per-frame configuration latch and
// a 16x oversampling baud divider restarted at every frame start.
module tx_top #(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned DBITS    = 8,
  parameter int unsigned SBITS    = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_wr,
  input  logic [DBITS-1:0] i_wr_data,
  input  logic             i_d_num,
  input  logic             i_s_num,
  input  logic [1:0]       i_par,
  input  logic [1:0]       i_bd_rate,
  output logic             o_tx,
  output logic             o_full,
  output logic             o_busy
);

  localparam int unsigned Ticks1200 = (CLK_FREQ + 1200 * 16 - 1) / (1200 * 16);
  localparam int unsigned Ticks2400 = (CLK_FREQ + 2400 * 16 - 1) / (2400 * 16);
  localparam int unsigned Ticks4800 = (CLK_FREQ + 4800 * 16 - 1) / (4800 * 16);
  localparam int unsigned Ticks9600 = (CLK_FREQ + 9600 * 16 - 1) / (9600 * 16);
  localparam int unsigned DivW      = $clog2(Ticks1200 + 1);
  localparam int unsigned PtrW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW      = $clog2(DEPTH + 1);
  localparam int unsigned MaxBits   = (DBITS > SBITS) ? DBITS : SBITS;
  localparam int unsigned BitW      = $clog2(MaxBits + 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e            state_q, state_d;
  logic [DivW-1:0]   div_q, div_d, div_max_q, div_max_d, div_max_sel;
  logic [3:0]        tick_cnt_q, tick_cnt_d;
  logic [BitW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [DBITS-1:0]  shreg_q, shreg_d;
  logic              d_num_q, d_num_d, s_num_q, s_num_d;
  logic              par_en_q, par_en_d, par_bit_q, par_bit_d;
  logic              tx_q, tx_d;

  logic [DBITS-1:0]  mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              empty, full, push, pop, start_frame;
  logic              tick, bit_end;
  logic [DBITS-1:0]  head, data_mask;
  logic [BitW-1:0]   last_data, last_stop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CntW'(DEPTH));
  // A write into a full FIFO is dropped even if a pop frees a slot this cycle.
  assign push  = i_wr && !full;
  assign pop   = start_frame;
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = (wr_ptr_q == PtrW'(DEPTH - 1)) ? '0 : wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = (rd_ptr_q == PtrW'(DEPTH - 1)) ? '0 : rd_ptr_q + PtrW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= i_wr_data;
  end

  always_comb begin
    div_max_sel = DivW'(Ticks1200 - 1);
    case (i_bd_rate)
      2'b00:   div_max_sel = DivW'(Ticks1200 - 1);
      2'b01:   div_max_sel = DivW'(Ticks2400 - 1);
      2'b10:   div_max_sel = DivW'(Ticks4800 - 1);
      default: div_max_sel = DivW'(Ticks9600 - 1);
    endcase
  end

  assign data_mask = i_d_num ? {DBITS{1'b1}} : {1'b0, {(DBITS - 1){1'b1}}};
  assign last_data = d_num_q ? BitW'(DBITS - 1) : BitW'(DBITS - 2);
  assign last_stop = s_num_q ? BitW'(SBITS - 1) : '0;
  assign tick      = (div_q == div_max_q);
  assign bit_end   = tick && (tick_cnt_q == 4'd15);

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    div_max_d   = div_max_q;
    tick_cnt_d  = tick_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    d_num_d     = d_num_q;
    s_num_d     = s_num_q;
    par_en_d    = par_en_q;
    par_bit_d   = par_bit_q;
    tx_d        = tx_q;
    start_frame = 1'b0;

    if (state_q != StIdle) begin
      div_d = tick ? '0 : div_q + DivW'(1);
      if (tick) tick_cnt_d = tick_cnt_q + 4'd1;
    end

    case (state_q)
      StIdle: begin
        tx_d = 1'b1;
        if (!empty) start_frame = 1'b1;
      end
      StStart: begin
        if (bit_end) begin
          state_d   = StData;
          tx_d      = shreg_q[0];
          shreg_d   = shreg_q >> 1;
          bit_cnt_d = '0;
        end
      end
      StData: begin
        if (bit_end) begin
          bit_cnt_d = '0;
          if (bit_cnt_q == last_data) begin
            state_d = par_en_q ? StParity : StStop;
            tx_d    = par_en_q ? par_bit_q : 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + BitW'(1);
            tx_d      = shreg_q[0];
            shreg_d   = shreg_q >> 1;
          end
        end
      end
      StParity: begin
        if (bit_end) begin
          state_d   = StStop;
          tx_d      = 1'b1;
          bit_cnt_d = '0;
        end
      end
      StStop: begin
        if (bit_end) begin
          if (bit_cnt_q != last_stop) begin
            bit_cnt_d = bit_cnt_q + BitW'(1);
          end else if (!empty) begin
            start_frame = 1'b1;
          end else begin
            state_d = StIdle;
            tx_d    = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Frame start: pop the head, snapshot the configuration, restart timing.
    if (start_frame) begin
      state_d    = StStart;
      tx_d       = 1'b0;
      div_d      = '0;
      tick_cnt_d = '0;
      bit_cnt_d  = '0;
      div_max_d  = div_max_sel;
      shreg_d    = head;
      d_num_d    = i_d_num;
      s_num_d    = i_s_num;
      par_en_d   = (i_par == 2'b01) || (i_par == 2'b10);
      par_bit_d  = (^(head & data_mask)) ^ (i_par == 2'b10);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= StIdle;
      div_q      <= '0;
      div_max_q  <= '0;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      d_num_q    <= 1'b0;
      s_num_q    <= 1'b0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      tx_q       <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      div_max_q  <= div_max_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      d_num_q    <= d_num_d;
      s_num_q    <= s_num_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      tx_q       <= tx_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  assign o_tx   = tx_q;
  assign o_full = full;
  assign o_busy = (state_q != StIdle);

endmodule

// File: tb/tb_tx_top.sv
// Bench for tx_top: stimulus pushes expected frames into a scoreboard, a monitor
// decodes the serial line cycle by cycle and checks every bit level and width.
module tb_tx_top;

  localparam int unsigned ClkFreq = 200_000;
  localparam int unsigned Depth   = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       d_num = 1'b1;
  logic       s_num = 1'b0;
  logic [1:0] par = 2'b00;
  logic [1:0] bd = 2'b00;
  logic       tx, full, busy;

  tx_top #(
    .CLK_FREQ(ClkFreq),
    .DEPTH   (Depth),
    .DBITS   (8),
    .SBITS   (2)
  ) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_wr     (wr),
    .i_wr_data(wr_data),
    .i_d_num  (d_num),
    .i_s_num  (s_num),
    .i_par    (par),
    .i_bd_rate(bd),
    .o_tx     (tx),
    .o_full   (full),
    .o_busy   (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] bits;
    int          nbits;
    int          blen;
    int          exp_start;
    bit          b2b;
    bit          last;
  } frame_t;

  frame_t     sb[$];
  logic [7:0] bq[$];
  int         full_log[16];
  int         total = 0;
  int         bad = 0;
  bit         mon_en = 1'b0;

  // Bit width in clocks straight from the baud formula: 16 * ceil(F / (16 * baud)).
  function automatic int bit_clocks(input logic [1:0] rate);
    int baud;
    case (rate)
      2'b00:   baud = 1200;
      2'b01:   baud = 2400;
      2'b10:   baud = 4800;
      default: baud = 9600;
    endcase
    return 16 * ((ClkFreq + baud * 16 - 1) / (baud * 16));
  endfunction

  function automatic frame_t build(input logic [7:0] b, input logic d8, input logic s2,
                                   input logic [1:0] p, input logic [1:0] rate);
    frame_t f;
    int     n = 0;
    logic   x = 1'b0;
    f.bits = '0;
    f.bits[n] = 1'b0;
    n++;
    for (int i = 0; i < (d8 ? 8 : 7); i++) begin
      f.bits[n] = b[i];
      x ^= b[i];
      n++;
    end
    if (p == 2'b01) begin
      f.bits[n] = x;
      n++;
    end else if (p == 2'b10) begin
      f.bits[n] = ~x;
      n++;
    end
    for (int i = 0; i < (s2 ? 2 : 1); i++) begin
      f.bits[n] = 1'b1;
      n++;
    end
    f.nbits = n;
    f.blen = bit_clocks(rate);
    f.exp_start = 0;
    f.b2b = 1'b0;
    f.last = 1'b0;
    return f;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic set_cfg(input int dn, input int sn, input int p, input int rate);
    @(negedge clk);
    d_num = 1'(dn);
    s_num = 1'(sn);
    par   = 2'(p);
    bd    = 2'(rate);
  endtask

  // Writes bq on consecutive cycles; the first `accept` bytes are expected on the line.
  task automatic send_burst(input int accept);
    frame_t f;
    for (int i = 0; i < bq.size(); i++) begin
      @(negedge clk);
      if (i > 0) full_log[i-1] = int'(full);
      if (i < accept) begin
        f = build(bq[i], d_num, s_num, par, bd);
        f.b2b = (i != 0);
        f.last = (i == accept - 1);
        f.exp_start = cyc + 2;
        sb.push_back(f);
      end
      wr = 1'b1;
      wr_data = bq[i];
    end
    @(negedge clk);
    full_log[bq.size()-1] = int'(full);
    wr = 1'b0;
  endtask

  task automatic wait_done(input int lim);
    int n = 0;
    @(negedge clk);
    while ((busy || sb.size() != 0) && n < lim) begin
      @(negedge clk);
      n++;
    end
    if (n >= lim) begin
      total++;
      bad++;
      $display("FAIL wait_done: still busy=%b pending=%0d after %0d cycles, expected idle",
               busy, sb.size(), lim);
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin : monitor
    frame_t f;
    int     t0;
    int     prev_end;
    int     badcyc;
    logic   last_tx, last_busy;
    prev_end = -1;
    forever begin
      @(negedge clk);
      if (mon_en && rst_n && tx === 1'b0) begin
        t0 = cyc;
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_frame: tx low at cycle %0d, expected idle high", t0);
          for (int k = 0; k < 20000 && tx === 1'b0; k++) @(negedge clk);
        end else begin
          f = sb.pop_front();
          check("start_cycle", t0, f.b2b ? prev_end : f.exp_start);
          for (int i = 0; i < f.nbits; i++) begin
            badcyc = 0;
            last_tx = f.bits[i];
            last_busy = 1'b1;
            for (int c = 0; c < f.blen; c++) begin
              if (i != 0 || c != 0) @(negedge clk);
              if (tx !== f.bits[i] || busy !== 1'b1) begin
                badcyc++;
                last_tx = tx;
                last_busy = busy;
              end
            end
            total++;
            if (badcyc != 0) begin
              bad++;
              $display("FAIL frame_bit%0d: tx=%b busy=%b on %0d of %0d cycles, expected tx=%b busy=1",
                       i, last_tx, last_busy, badcyc, f.blen, f.bits[i]);
            end
          end
          prev_end = t0 + f.nbits * f.blen;
          if (f.last) begin
            @(negedge clk);
            check("idle_after_frame", {30'd0, busy, tx}, 32'd1);
          end
        end
      end
    end
  end

  initial begin : stim
    int n;
    int busy_seen;
    repeat (3) @(negedge clk);
    check("reset_tx", tx, 1);
    check("reset_busy", busy, 0);
    check("reset_full", full, 0);
    rst_n = 1'b1;
    mon_en = 1'b1;

    // 8N1 at 1200 baud, 0xA5
    set_cfg(1, 0, 0, 0);
    bq.delete(); bq.push_back(8'hA5);
    send_burst(1);
    wait_done(8000);

    // 7N2, 0xB5: bit 7 must never appear on the line
    set_cfg(0, 1, 0, 2);
    bq.delete(); bq.push_back(8'hB5);
    send_burst(1);
    wait_done(8000);

    // 0x03 with even then odd parity
    set_cfg(1, 0, 1, 1);
    bq.delete(); bq.push_back(8'h03);
    send_burst(1);
    wait_done(8000);
    set_cfg(1, 0, 2, 1);
    bq.delete(); bq.push_back(8'h03);
    send_burst(1);
    wait_done(8000);

    // 9600 8E1, 0x81
    set_cfg(1, 0, 1, 3);
    bq.delete(); bq.push_back(8'h81);
    send_burst(1);
    wait_done(8000);

    // Overflow: 10 writes while idle, the 10th lands on a full FIFO
    set_cfg(1, 0, 0, 3);
    bq.delete();
    for (int i = 0; i < 10; i++) bq.push_back(8'h30 + 8'(i * 7));
    send_burst(9);
    check("full_after_8th", full_log[7], 0);
    check("full_after_9th", full_log[8], 1);
    check("full_after_10th", full_log[9], 1);
    wait_done(8000);
    check("full_after_drain", full, 0);

    // Random bursts; single-byte frames get their config scrambled mid-frame
    for (int it = 0; it < 16; it++) begin
      set_cfg(int'($urandom_range(1, 0)), int'($urandom_range(1, 0)),
              int'($urandom_range(3, 0)), int'($urandom_range(3, 0)));
      n = int'($urandom_range(3, 1));
      bq.delete();
      for (int j = 0; j < n; j++) bq.push_back(8'($urandom));
      send_burst(n);
      if (n == 1) begin
        for (int k = 0; k < 10 && !busy; k++) @(negedge clk);
        set_cfg(int'($urandom_range(1, 0)), int'($urandom_range(1, 0)),
                int'($urandom_range(3, 0)), int'($urandom_range(3, 0)));
      end
      wait_done(8000);
    end

    // Reset during DATA with 3 bytes queued
    mon_en = 1'b0;
    set_cfg(1, 0, 0, 3);
    bq.delete();
    for (int i = 0; i < 4; i++) bq.push_back(8'hC0 + 8'(i));
    send_burst(0);
    repeat (2 * bit_clocks(2'b11) + 10) @(negedge clk);
    check("busy_before_reset", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_tx", tx, 1);
    check("midreset_busy", busy, 0);
    check("midreset_full", full, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;
    busy_seen = 0;
    repeat (1200) begin
      @(negedge clk);
      if (busy) busy_seen++;
    end
    check("no_resume_busy_cycles", busy_seen, 0);
    check("scoreboard_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
